// File: rtl/cache_bank_requester_if.sv
`default_nettype none
// ============================================================================
// Module  : cache_bank_client_if / cache_bank_port_if
// Purpose : Bundles for the cache bank request sequencer.
//           cache_bank_client_if - client request/response handshakes
//             master : the client (drives requests, takes responses)
//             slave  : the sequencer
//           cache_bank_port_if   - one port of a dual-port cacheBank
//             master : the sequencer (drives address/data/write enable)
//             slave  : the bank (returns read data and writtenTo)
// Widths  : `DATA_WIDTH and `CACHE_BANK_ADDRESS_WIDTH, defaulting to 8 when
//           globalVariables.v has not already defined them.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif

interface cache_bank_client_if;
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_write;
  logic [`CACHE_BANK_ADDRESS_WIDTH-1:0] req_addr;
  logic [`DATA_WIDTH-1:0]               req_wdata;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic                                 rsp_write;
  logic [`DATA_WIDTH-1:0]               rsp_rdata;
  logic                                 rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error
  );
endinterface

interface cache_bank_port_if;
  logic [`CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressIn;
  logic [`DATA_WIDTH-1:0]               cacheDataIn;
  logic                                 memWrite;
  logic [`DATA_WIDTH-1:0]               cacheDataOut;
  logic                                 writtenTo;

  modport master (
    output cacheAddressIn, cacheDataIn, memWrite,
    input  cacheDataOut, writtenTo
  );
  modport slave (
    input  cacheAddressIn, cacheDataIn, memWrite,
    output cacheDataOut, writtenTo
  );
endinterface

`default_nettype wire

// File: rtl/cache_bank_requester.sv
`default_nettype none
// ============================================================================
// Module  : cache_bank_requester
// Purpose : Buffers client read/write requests in a small FIFO and issues them
//           one at a time to one port of a dual-port cacheBank, returning one
//           in-order response per request.
// Ports   : clk     - rising-edge clock
//           reset   - asynchronous, active-low
//           client  - cache_bank_client_if.slave (request/response handshakes)
//           bank    - cache_bank_port_if.master (bank port address/data/we)
// Params  : FIFO_DEPTH   - request FIFO entries (power of two, >= 2)
//           READ_LATENCY - cycles from issue edge until cacheDataOut is valid
//           MAX_RETRIES  - write re-issues before an error response
// Macro   : CACHE_BANK_WRITE_CONFIRM_EN - when defined, a write whose
//           writtenTo comes back 0 is re-issued up to MAX_RETRIES times, then
//           answered with rsp_error = 1. When undefined writtenTo is ignored.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif

module cache_bank_requester #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int MAX_RETRIES  = 3
) (
  input wire                  clk,
  input wire                  reset,
  cache_bank_client_if.slave  client,
  cache_bank_port_if.master   bank
);

  localparam int c_DW    = `DATA_WIDTH;
  localparam int c_AW    = `CACHE_BANK_ADDRESS_WIDTH;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [c_AW-1:0]  r_fifo_addr  [FIFO_DEPTH];
  logic [c_DW-1:0]  r_fifo_wdata [FIFO_DEPTH];
  logic             r_fifo_write [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [c_PTR_W:0] r_wptr;
  logic [c_PTR_W:0] r_rptr;

  state_t           r_state;
  logic             w_empty;
  logic             w_full;
  logic             w_req_ready;
  logic             w_push;
  logic             w_pop;
  logic [c_PTR_W-1:0] w_head;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) &&
                       (r_wptr[c_PTR_W-1:0] == r_rptr[c_PTR_W-1:0]);
  // Held low for as long as reset is asserted, not just until the next edge.
  assign w_req_ready = reset & ~w_full;
  assign w_push      = client.req_valid & w_req_ready;
  // The head is taken whenever the sequencer is free: idle, or its pending
  // response is being accepted this cycle.
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) |
                                   ((r_state == S_RESP) & client.rsp_ready));
  assign w_head      = r_rptr[c_PTR_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr [r_wptr[c_PTR_W-1:0]] <= client.req_addr;
      r_fifo_wdata[r_wptr[c_PTR_W-1:0]] <= client.req_wdata;
      r_fifo_write[r_wptr[c_PTR_W-1:0]] <= client.req_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= r_wptr + (c_PTR_W+1)'(1);
    end
  end

  // ---------------------------------------------------------------- FSM
  logic              r_cur_write;
  logic [c_LAT_W-1:0] r_lat_cnt;
  logic [c_AW-1:0]   r_cache_addr;
  logic [c_DW-1:0]   r_cache_data;
  logic              r_mem_write;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [c_DW-1:0]   r_rsp_rdata;
  logic              r_rsp_error;

`ifdef CACHE_BANK_WRITE_CONFIRM_EN
  localparam int c_RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [c_RTY_W-1:0] r_retry;
`else
  logic w_unused_writtento;
  assign w_unused_writtento = bank.writtenTo;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rptr       <= '0;
      r_cur_write  <= 1'b0;
      r_lat_cnt    <= '0;
      r_cache_addr <= '0;
      r_cache_data <= '0;
      r_mem_write  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_error  <= 1'b0;
`ifdef CACHE_BANK_WRITE_CONFIRM_EN
      r_retry      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_ISSUE: begin
          r_mem_write <= 1'b0;
          r_lat_cnt   <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cur_write) begin
`ifdef CACHE_BANK_WRITE_CONFIRM_EN
            // writtenTo low means the other port won a same-address collision.
            if (!bank.writtenTo && (r_retry < c_RTY_W'(MAX_RETRIES))) begin
              r_retry     <= r_retry + c_RTY_W'(1);
              r_mem_write <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_write <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_error <= ~bank.writtenTo;
              r_state     <= S_RESP;
            end
`else
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_state     <= S_RESP;
`endif
          end else if (r_lat_cnt == c_LAT_LAST) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= bank.cacheDataOut;
            r_rsp_error <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
          end
        end
        S_RESP: begin
          if (client.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Taking the head overrides the IDLE/RESP decisions above so a queued
      // request issues straight after the previous response is accepted.
      if (w_pop) begin
        r_rptr       <= r_rptr + (c_PTR_W+1)'(1);
        r_cur_write  <= r_fifo_write[w_head];
        r_cache_addr <= r_fifo_addr[w_head];
        r_cache_data <= r_fifo_wdata[w_head];
        r_mem_write  <= r_fifo_write[w_head];
`ifdef CACHE_BANK_WRITE_CONFIRM_EN
        r_retry      <= '0;
`endif
        r_state      <= S_ISSUE;
      end
    end
  end

  assign client.req_ready   = w_req_ready;
  assign client.rsp_valid   = r_rsp_valid;
  assign client.rsp_write   = r_rsp_write;
  assign client.rsp_rdata   = r_rsp_rdata;
  assign client.rsp_error   = r_rsp_error;
  assign bank.cacheAddressIn = r_cache_addr;
  assign bank.cacheDataIn    = r_cache_data;
  assign bank.memWrite       = r_mem_write;

endmodule

`default_nettype wire

// File: tb/tb_cache_bank_requester.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_bank_requester
// Purpose : Self-checking bench for cache_bank_requester. A behavioural bank
//           model answers the port; a scoreboard of expected responses is
//           filled as requests are accepted and drained as responses are
//           handshaken. Directed sequences cover reset, latency, FIFO full,
//           backpressure, write retries and reset mid-operation.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif

module tb_cache_bank_requester;

  localparam int c_DW = `DATA_WIDTH;
  localparam int c_AW = `CACHE_BANK_ADDRESS_WIDTH;

  typedef struct {
    logic            wr;
    logic [c_AW-1:0] addr;
    logic [c_DW-1:0] wdata;
    logic [c_DW-1:0] exp_rdata;
    logic            exp_err;
  } vec_t;

  typedef struct {
    logic            wr;
    logic [c_DW-1:0] rdata;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_bank_client_if cli ();
  cache_bank_port_if   bnk ();

  cache_bank_requester #(
    .FIFO_DEPTH   (4),
    .READ_LATENCY (1),
    .MAX_RETRIES  (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .client (cli),
    .bank   (bnk)
  );

  // ------------------------------------------------------------ bank model
  logic [c_DW-1:0] bank_mem [1 << c_AW] = '{default: '0};
  int wt_pulses = 0;
  int wt_base   = 0;
  int ok_after  = 0;

  always @(posedge clk) begin
    bnk.cacheDataOut <= bank_mem[bnk.cacheAddressIn];
    if (bnk.memWrite) begin
      bank_mem[bnk.cacheAddressIn] <= bnk.cacheDataIn;
      wt_pulses <= wt_pulses + 1;
    end
  end
  // writtenTo stays 0 until ok_after write pulses have been seen.
  assign bnk.writtenTo = ((wt_pulses - wt_base) >= ok_after);

  // ------------------------------------------------------------ bookkeeping
  int checks = 0;
  int errors = 0;
  int mw_cnt = 0;
  int rsp_cnt = 0;
  logic [c_AW-1:0] last_mw_addr = '0;
  logic [c_DW-1:0] ref_mem [1 << c_AW] = '{default: '0};
  exp_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bnk.memWrite) begin
          mw_cnt++;
          last_mw_addr = bnk.cacheAddressIn;
        end
        if (cli.rsp_valid && cli.rsp_ready) begin
          rsp_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp actual=write:%b rdata:%0h required=no response",
                     cli.rsp_write, cli.rsp_rdata);
          end else begin
            e = sb.pop_front();
            if (cli.rsp_write !== e.wr || cli.rsp_rdata !== e.rdata || cli.rsp_error !== e.err) begin
              errors++;
              $display("FAIL rsp actual=w%b/d%0h/e%b required=w%b/d%0h/e%b",
                       cli.rsp_write, cli.rsp_rdata, cli.rsp_error, e.wr, e.rdata, e.err);
            end
          end
        end
      end
    end
  endtask

  task automatic send(input logic w, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d,
                      input logic [c_DW-1:0] er, input logic ee);
    int   n;
    exp_t e;
    cli.req_valid = 1'b1;
    cli.req_write = w;
    cli.req_addr  = a;
    cli.req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cli.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cli.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%0h actual=req_ready %b required=1", a, cli.req_ready);
    end else begin
      e.wr    = w;
      e.rdata = w ? '0 : er;
      e.err   = ee;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    cli.req_valid = 1'b0;
  endtask

  task automatic send_ref(input logic w, input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
    logic [c_DW-1:0] er;
    er = ref_mem[a];
    if (w) ref_mem[a] = d;
    send(w, a, d, er, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mw0;
    int rsp0;
    int exp_p1, exp_p2;
    logic exp_e2;
    logic [c_AW-1:0] addr0;

    vecs[0] = '{1'b1, c_AW'(8'h04), c_DW'(8'h02), c_DW'(8'h00), 1'b0};
    vecs[1] = '{1'b0, c_AW'(8'h04), c_DW'(8'h00), c_DW'(8'h02), 1'b0};
    vecs[2] = '{1'b1, c_AW'(8'h10), c_DW'(8'hA5), c_DW'(8'h00), 1'b0};
    vecs[3] = '{1'b1, c_AW'(8'h11), c_DW'(8'h5A), c_DW'(8'h00), 1'b0};
    vecs[4] = '{1'b0, c_AW'(8'h10), c_DW'(8'h00), c_DW'(8'hA5), 1'b0};
    vecs[5] = '{1'b0, c_AW'(8'h11), c_DW'(8'h00), c_DW'(8'h5A), 1'b0};
    vecs[6] = '{1'b1, c_AW'(8'h04), c_DW'(8'hFF), c_DW'(8'h00), 1'b0};
    vecs[7] = '{1'b0, c_AW'(8'h04), c_DW'(8'h00), c_DW'(8'hFF), 1'b0};
    vecs[8] = '{1'b0, c_AW'(8'h12), c_DW'(8'h00), c_DW'(8'h00), 1'b0};
    vecs[9] = '{1'b0, c_AW'(8'h10), c_DW'(8'h00), c_DW'(8'hA5), 1'b0};

    reset         = 1'b0;
    cli.req_valid = 1'b0;
    cli.req_write = 1'b0;
    cli.req_addr  = '0;
    cli.req_wdata = '0;
    cli.rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset for two cycles, then release.
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_req_ready", cli.req_ready, 0);
    reset = 1'b1;
    #1;
    chk("rst_req_ready",  cli.req_ready, 1);
    chk("rst_rsp_valid",  cli.rsp_valid, 0);
    chk("rst_rsp_write",  cli.rsp_write, 0);
    chk("rst_rsp_rdata",  cli.rsp_rdata, 0);
    chk("rst_rsp_error",  cli.rsp_error, 0);
    chk("rst_memWrite",   bnk.memWrite, 0);
    chk("rst_addr",       bnk.cacheAddressIn, 0);
    chk("rst_data",       bnk.cacheDataIn, 0);
    @(posedge clk);
    #1;

    // First write: one memWrite pulse at address 0x04.
    mw0 = mw_cnt;
    send_ref(1'b1, c_AW'(8'h04), c_DW'(8'h02));
    drain();
    chk("first_write_pulses", mw_cnt - mw0, 1);
    chk("first_write_addr", last_mw_addr, 8'h04);

    // Read latency: response 3 edges after the accepting edge.
    send_ref(1'b0, c_AW'(8'h04), '0);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (cli.rsp_valid) break;
    end
    chk("read_latency", n, 3);
    chk("read_rdata", cli.rsp_rdata, 8'h02);
    drain();

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) ref_mem[vecs[i].addr] = vecs[i].wdata;
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    drain();

    // FIFO full and wrap.
    rsp0 = rsp_cnt;
    cli.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_ref((i % 2) == 0, c_AW'(48 + i - (i % 2)), c_DW'(128 + i));
    @(negedge clk);
    chk("fifo_full_ready", cli.req_ready, 0);
    repeat (3) @(negedge clk);
    chk("fifo_full_ready_hold", cli.req_ready, 0);
    @(posedge clk);
    #1;
    cli.rsp_ready = 1'b1;
    for (int i = 5; i < 9; i++)
      send_ref((i % 2) == 0, c_AW'(48 + i - (i % 2)), c_DW'(128 + i));
    drain();
    chk("fifo_rsp_count", rsp_cnt - rsp0, 9);

    // Backpressure on a read response of 0x07.
    send_ref(1'b1, c_AW'(8'h20), c_DW'(8'h07));
    drain();
    cli.rsp_ready = 1'b0;
    send_ref(1'b0, c_AW'(8'h20), '0);
    n = 0;
    while (!cli.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_rsp_seen", cli.rsp_valid, 1);
    addr0 = bnk.cacheAddressIn;
    send_ref(1'b1, c_AW'(8'h21), c_DW'(8'h33));
    mw0 = mw_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {cli.rsp_valid, cli.rsp_rdata, bnk.memWrite, bnk.cacheAddressIn},
          {1'b1, c_DW'(8'h07), 1'b0, addr0});
    end
    chk("bp_no_issue", mw_cnt - mw0, 0);
    @(posedge clk);
    #1;
    cli.rsp_ready = 1'b1;
    drain();

    // Collision retries.
`ifdef CACHE_BANK_WRITE_CONFIRM_EN
    exp_p1 = 3;
    exp_p2 = 4;
    exp_e2 = 1'b1;
`else
    exp_p1 = 1;
    exp_p2 = 1;
    exp_e2 = 1'b0;
`endif
    wt_base  = wt_pulses;
    ok_after = 3;
    mw0 = mw_cnt;
    ref_mem[6] = c_DW'(8'h03);
    send(1'b1, c_AW'(8'h06), c_DW'(8'h03), '0, 1'b0);
    drain();
    chk("retry_ok_pulses", mw_cnt - mw0, exp_p1);
    wt_base  = wt_pulses;
    ok_after = 1000;
    mw0 = mw_cnt;
    send(1'b1, c_AW'(8'h06), c_DW'(8'h03), '0, exp_e2);
    drain();
    chk("retry_stuck_pulses", mw_cnt - mw0, exp_p2);
    ok_after = 0;

    // Reset during the WAIT cycle of a read with two requests queued.
    send_ref(1'b0, c_AW'(8'h10), '0);
    send_ref(1'b0, c_AW'(8'h11), '0);
    send_ref(1'b0, c_AW'(8'h12), '0);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", cli.rsp_valid, 0);
    chk("midrst_memWrite", bnk.memWrite, 0);
    chk("midrst_addr", bnk.cacheAddressIn, 0);
    chk("midrst_req_ready", cli.req_ready, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rsp0 = rsp_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_rsp", rsp_cnt - rsp0, 0);
    chk("midrst_ready_after", cli.req_ready, 1);

    // Normal operation resumes after the mid-operation reset.
    send_ref(1'b0, c_AW'(8'h11), '0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
